// File: rtl/uart_boot_streamer.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_streamer
// Purpose  : Host-side boot-stream engine. For each of NSEC sections it waits
//            for that section's sync byte from the core's UART TX, optionally
//            sends a 32-bit little-endian byte-count header, then streams the
//            section's words from a synchronous-read word memory to the core's
//            UART RX, one byte at a time, in the configured byte order.
// Ports    : clk, resetn          - clock, asynchronous active-low reset
//            rx_data/rx_ready     - received byte and its 1-cycle strobe
//            tx_data/tx_start     - byte and send request towards uart_tx
//            tx_busy              - uart_tx busy flag
//            mem_addr/mem_en      - word read port (data 1 cycle after mem_en)
//            mem_rdata            - memory read data
//            sec_base/len/sync/hdr- packed per-section configuration
//            abort                - synchronous restart to section 0
//            sec_idx/busy/done    - progress status
//            bytes_sent           - bytes handed to uart_tx since reset/abort
// Revision : 1.0 - initial release
// ============================================================================
module uart_boot_streamer #(
  parameter int NSEC       = 2,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 15,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_en,
  input  logic [WORD_W-1:0]      mem_rdata,
  input  logic [NSEC*ADDR_W-1:0] sec_base,
  input  logic [NSEC*ADDR_W-1:0] sec_len,
  input  logic [NSEC*8-1:0]      sec_sync,
  input  logic [NSEC-1:0]        sec_hdr,
  input  logic                   abort,
  output logic [$clog2(NSEC):0]  sec_idx,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            bytes_sent
);

  localparam int SIW = $clog2(NSEC) + 1;
  localparam int NB  = WORD_W / 8;

  localparam logic [2:0] c_SYNC      = 3'd0;
  localparam logic [2:0] c_HDR_SEND  = 3'd1;
  localparam logic [2:0] c_HDR_WAIT  = 3'd2;
  localparam logic [2:0] c_FETCH     = 3'd3;
  localparam logic [2:0] c_LOAD      = 3'd4;
  localparam logic [2:0] c_BYTE_SEND = 3'd5;
  localparam logic [2:0] c_BYTE_WAIT = 3'd6;
  localparam logic [2:0] c_DONE      = 3'd7;

  localparam logic [3:0]     c_LAST_HDR_BYTE = 4'd3;
  localparam logic [3:0]     c_LAST_PAY_BYTE = 4'(NB - 1);
  localparam logic [SIW-1:0] c_LAST_SEC      = SIW'(NSEC - 1);
  localparam logic [ADDR_W:0] c_ONE_IDX      = (ADDR_W+1)'(1);

  logic [2:0]        r_state;
  logic [SIW-1:0]    r_sec_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_word_idx;
  logic [3:0]        r_byte_cnt;
  logic [31:0]       r_hdr;
  logic [WORD_W-1:0] r_shift;
  logic [31:0]       r_bytes_sent;

  logic [ADDR_W-1:0] w_cur_base;
  logic [ADDR_W-1:0] w_cur_len;
  logic [7:0]        w_cur_sync;
  logic              w_cur_hdr;
  logic              w_sync_hit;
  logic [31:0]       w_hdr_val;
  logic              w_more_words;
  logic [7:0]        w_pay_byte;
  logic [WORD_W-1:0] w_shift_nxt;

  // Configuration of the section currently waiting for its sync byte.
  always_comb begin
    w_cur_base = '0;
    w_cur_len  = '0;
    w_cur_sync = '0;
    w_cur_hdr  = 1'b0;
    for (int i = 0; i < NSEC; i++) begin
      if (r_sec_idx == SIW'(i)) begin
        w_cur_base = sec_base[i*ADDR_W +: ADDR_W];
        w_cur_len  = sec_len[i*ADDR_W +: ADDR_W];
        w_cur_sync = sec_sync[i*8 +: 8];
        w_cur_hdr  = sec_hdr[i];
      end
    end
  end

  assign w_sync_hit   = rx_ready && (rx_data == w_cur_sync);
  assign w_hdr_val    = 32'(w_cur_len) * 32'(NB);
  // One extra bit so that index+1 cannot wrap when len is at its maximum.
  assign w_more_words = ({1'b0, r_word_idx} + c_ONE_IDX) < {1'b0, r_len};

  if (BIG_ENDIAN != 0) begin : g_msb_first
    assign w_pay_byte  = r_shift[WORD_W-1 -: 8];
    assign w_shift_nxt = r_shift << 8;
  end else begin : g_lsb_first
    assign w_pay_byte  = r_shift[7:0];
    assign w_shift_nxt = r_shift >> 8;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= c_SYNC;
      r_sec_idx    <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_hdr        <= '0;
      r_shift      <= '0;
      r_bytes_sent <= '0;
    end else if (abort) begin
      // A byte already inside uart_tx finishes on its own; nothing waits for it.
      r_state      <= c_SYNC;
      r_sec_idx    <= '0;
      r_addr       <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_bytes_sent <= '0;
    end else begin
      case (r_state)
        c_SYNC: begin
          if (w_sync_hit) begin
            r_addr     <= w_cur_base;
            r_len      <= w_cur_len;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_hdr      <= w_hdr_val;
            r_state    <= w_cur_hdr ? c_HDR_SEND : c_FETCH;
          end
        end
        c_HDR_SEND: begin
          if (tx_busy) begin
            r_state      <= c_HDR_WAIT;
            r_bytes_sent <= r_bytes_sent + 32'd1;
          end
        end
        c_HDR_WAIT: begin
          if (!tx_busy) begin
            r_hdr <= {8'h00, r_hdr[31:8]};
            if (r_byte_cnt == c_LAST_HDR_BYTE) begin
              r_byte_cnt <= '0;
              r_state    <= c_FETCH;
            end else begin
              r_byte_cnt <= r_byte_cnt + 4'd1;
              r_state    <= c_HDR_SEND;
            end
          end
        end
        c_FETCH: begin
          if (r_len == '0) begin
            r_sec_idx <= r_sec_idx + SIW'(1);
            r_state   <= (r_sec_idx == c_LAST_SEC) ? c_DONE : c_SYNC;
          end else begin
            r_state <= c_LOAD;
          end
        end
        c_LOAD: begin
          r_shift <= mem_rdata;
          r_state <= c_BYTE_SEND;
        end
        c_BYTE_SEND: begin
          if (tx_busy) begin
            r_state      <= c_BYTE_WAIT;
            r_bytes_sent <= r_bytes_sent + 32'd1;
          end
        end
        c_BYTE_WAIT: begin
          if (!tx_busy) begin
            r_shift <= w_shift_nxt;
            if (r_byte_cnt == c_LAST_PAY_BYTE) begin
              r_byte_cnt <= '0;
              if (w_more_words) begin
                r_word_idx <= r_word_idx + ADDR_W'(1);
                r_addr     <= r_addr + ADDR_W'(1);
                r_state    <= c_FETCH;
              end else begin
                r_sec_idx <= r_sec_idx + SIW'(1);
                r_state   <= (r_sec_idx == c_LAST_SEC) ? c_DONE : c_SYNC;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 4'd1;
              r_state    <= c_BYTE_SEND;
            end
          end
        end
        c_DONE: begin
          r_state <= c_DONE;
        end
        default: begin
          r_state <= c_SYNC;
        end
      endcase
    end
  end

  // tx_data only carries a byte while a header/payload transfer is in flight.
  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      c_HDR_SEND, c_HDR_WAIT:   tx_data = r_hdr[7:0];
      c_BYTE_SEND, c_BYTE_WAIT: tx_data = w_pay_byte;
      default:                  tx_data = 8'h00;
    endcase
  end

  assign tx_start   = (r_state == c_HDR_SEND) || (r_state == c_BYTE_SEND);
  // Zero-length sections pass through FETCH without touching the memory.
  assign mem_en     = (r_state == c_FETCH) && (r_len != '0);
  assign mem_addr   = r_addr;
  assign sec_idx    = r_sec_idx;
  assign busy       = (r_state != c_SYNC) && (r_state != c_DONE);
  assign done       = (r_state == c_DONE);
  assign bytes_sent = r_bytes_sent;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_streamer
// Purpose  : Self-checking bench for uart_boot_streamer. Expected bytes are
//            queued when a sync byte is issued; a UART model pops and compares
//            each byte as it is accepted from the streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_streamer;

  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetn;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_busy;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_en;
  logic [31:0]         mem_rdata;
  logic [2*ADDR_W-1:0] sec_base;
  logic [2*ADDR_W-1:0] sec_len;
  logic [15:0]         sec_sync;
  logic [1:0]          sec_hdr;
  logic                abort;
  logic [1:0]          sec_idx;
  logic                busy;
  logic                done;
  logic [31:0]         bytes_sent;

  logic [ADDR_W-1:0] cfg_base [2];
  logic [ADDR_W-1:0] cfg_len  [2];
  logic [7:0]        cfg_sync [2];
  logic              cfg_hdr  [2];

  assign sec_base = {cfg_base[1], cfg_base[0]};
  assign sec_len  = {cfg_len[1], cfg_len[0]};
  assign sec_sync = {cfg_sync[1], cfg_sync[0]};
  assign sec_hdr  = {cfg_hdr[1], cfg_hdr[0]};

  // Second instance: single big-endian section.
  logic [7:0]        be_rx_data;
  logic              be_rx_ready;
  logic [7:0]        be_tx_data;
  logic              be_tx_start;
  logic              be_tx_busy;
  logic [ADDR_W-1:0] be_addr;
  logic              be_en;
  logic [31:0]       be_rdata;
  logic [0:0]        be_sec_idx;
  logic              be_busy;
  logic              be_done;
  logic [31:0]       be_bytes_sent;

  uart_boot_streamer #(.NSEC(2), .WORD_W(32), .ADDR_W(ADDR_W), .BIG_ENDIAN(0)) u_dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
    .sec_base(sec_base), .sec_len(sec_len), .sec_sync(sec_sync), .sec_hdr(sec_hdr),
    .abort(abort), .sec_idx(sec_idx), .busy(busy), .done(done), .bytes_sent(bytes_sent)
  );

  uart_boot_streamer #(.NSEC(1), .WORD_W(32), .ADDR_W(ADDR_W), .BIG_ENDIAN(1)) u_dut_be (
    .clk(clk), .resetn(resetn), .rx_data(be_rx_data), .rx_ready(be_rx_ready),
    .tx_data(be_tx_data), .tx_start(be_tx_start), .tx_busy(be_tx_busy),
    .mem_addr(be_addr), .mem_en(be_en), .mem_rdata(be_rdata),
    .sec_base(15'd0), .sec_len(15'd1), .sec_sync(8'h5A), .sec_hdr(1'b1),
    .abort(1'b0), .sec_idx(be_sec_idx), .busy(be_busy), .done(be_done),
    .bytes_sent(be_bytes_sent)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word memory shared by both instances, 1-cycle read latency.
  logic [31:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
    if (be_en)  be_rdata  <= ram[be_addr];
  end

  int mem_en_cnt = 0;
  always @(negedge clk) if (mem_en) mem_en_cnt++;

  // Scoreboards.
  logic [7:0] exp_q[$];
  logic [7:0] be_exp_q[$];

  // UART TX model / monitor for the main instance: random accept delay and
  // random busy length; 'hold' pins tx_busy high to model a stalled UART.
  bit hold = 1'b0;
  int left = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      tx_busy = 1'b0;
    end else if (hold) begin
      tx_busy = 1'b1;
    end else if (tx_busy) begin
      if (left == 0) tx_busy = 1'b0;
      else left--;
    end else if (tx_start && ($urandom_range(0, 2) != 0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL tx_byte: got 0x%02h, expected no byte", tx_data);
      end else begin
        chk("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
      end
      tx_busy = 1'b1;
      left    = int'($urandom_range(1, 5));
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      be_tx_busy = 1'b0;
    end else if (be_tx_busy) begin
      be_tx_busy = 1'b0;
    end else if (be_tx_start) begin
      if (be_exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL be_tx_byte: got 0x%02h, expected no byte", be_tx_data);
      end else begin
        chk("be_tx_byte", 64'(be_tx_data), 64'(be_exp_q.pop_front()));
      end
      be_tx_busy = 1'b1;
    end
  end

  // Reference model: header = len*4 LSB first, then each word LSB first.
  task automatic push_section(input int s);
    logic [31:0]       h;
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
    if (cfg_hdr[s]) begin
      h = 32'(cfg_len[s]) * 32'd4;
      for (int k = 0; k < 4; k++) exp_q.push_back(h[8*k +: 8]);
    end
    for (int i = 0; i < int'(cfg_len[s]); i++) begin
      a = cfg_base[s] + ADDR_W'(i);
      w = ram[a];
      for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
    end
  endtask

  function automatic int section_bytes(input int s);
    return (cfg_hdr[s] ? 4 : 0) + 4 * int'(cfg_len[s]);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns 1 time unit after the edge at which the byte was sampled.
  task automatic send_byte(input logic [7:0] b, input bit to_be);
    @(posedge clk);
    #1;
    if (to_be) begin
      be_rx_data  = b;
      be_rx_ready = 1'b1;
    end else begin
      rx_data  = b;
      rx_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rx_ready    = 1'b0;
    be_rx_ready = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic wait_sec(input int target, input string name);
    int n = 0;
    while (!(int'(sec_idx) == target && !busy) && n < 5000) begin
      tick(1);
      n++;
    end
    chk(name, 64'(int'(sec_idx) == target && !busy), 64'd1);
  endtask

  task automatic wait_bytes(input int target, input string name);
    int n = 0;
    while (int'(bytes_sent) < target && n < 5000) begin
      tick(1);
      n++;
    end
    chk(name, 64'(bytes_sent), 64'(target));
  endtask

  task automatic cycles_to_start(output int n);
    n = 0;
    while (!tx_start && n < 20) begin
      tick(1);
      n++;
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, 64'({tx_data, tx_start, mem_addr, mem_en, sec_idx, busy, done, bytes_sent}), 64'd0);
  endtask

  task automatic set_cfg(input int s, input int base, input int len,
                         input logic [7:0] sync, input bit hdr);
    cfg_base[s] = ADDR_W'(base);
    cfg_len[s]  = ADDR_W'(len);
    cfg_sync[s] = sync;
    cfg_hdr[s]  = hdr;
  endtask

  initial begin
    automatic int n;
    automatic int total;
    automatic int cnt;
    automatic int m0;
    resetn = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; abort = 1'b0;
    be_rx_data = 8'h00; be_rx_ready = 1'b0;
    set_cfg(0, 0, 2, 8'h99, 1'b1);
    set_cfg(1, 2, 1, 8'hAA, 1'b0);
    for (int i = 0; i < 32768; i++) ram[i] = $urandom;
    ram[0] = 32'h11223344;
    ram[1] = 32'h55667788;
    ram[2] = 32'hDEADBEEF;
    tick(3);
    chk_outputs_zero("reset_outputs");
    chk("reset_be_outputs", 64'({be_tx_start, be_busy, be_done, be_sec_idx, be_bytes_sent}), 64'd0);
    resetn = 1'b1;
    tick(2);

    // Big-endian payload, header still LSB first.
    foreach (be_exp_q[i]) be_exp_q.delete(i);
    be_exp_q = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_byte(8'h5A, 1'b1);
    n = 0;
    while (!be_done && n < 500) begin tick(1); n++; end
    chk("be_done", 64'(be_done), 64'd1);
    chk("be_bytes_sent", 64'(be_bytes_sent), 64'd8);
    chk("be_queue_empty", 64'(be_exp_q.size()), 64'd0);

    // Two-section download with header on section 0.
    push_section(0);
    send_byte(8'h99, 1'b0);
    cycles_to_start(n);
    chk("latency_hdr", 64'(n), 64'd0);
    if (busy) send_byte(8'hAA, 1'b0);
    if (busy) send_byte(8'h99, 1'b0);
    wait_sec(1, "sec0_end");
    chk("sec0_bytes", 64'(bytes_sent), 64'd12);
    chk("sec0_queue_empty", 64'(exp_q.size()), 64'd0);
    send_byte(8'h55, 1'b0);
    tick(20);
    chk("wrong_sync_ignored", 64'({busy, bytes_sent}), 64'd12);
    push_section(1);
    send_byte(8'hAA, 1'b0);
    cycles_to_start(n);
    chk("latency_nohdr", 64'(n), 64'd2);
    n = 0;
    while (!done && n < 500) begin tick(1); n++; end
    chk("done_after_sec1", 64'({done, sec_idx}), 64'({1'b1, 2'd2}));
    chk("total_bytes", 64'(bytes_sent), 64'd16);
    chk("sec1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort during the 3rd payload byte, then replay.
    do_abort();
    chk("abort_clears_done", 64'({done, sec_idx, bytes_sent}), 64'd0);
    push_section(0);
    repeat (5) void'(exp_q.pop_back());
    send_byte(8'h99, 1'b0);
    wait_bytes(7, "abort_reach_byte3");
    chk("abort_busy_high", 64'(tx_busy), 64'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_state", 64'({sec_idx, bytes_sent, tx_start, busy, done}), 64'd0);
    chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    tick(10);
    push_section(0);
    send_byte(8'h99, 1'b0);
    cycles_to_start(n);
    chk("replay_latency_hdr", 64'(n), 64'd0);
    wait_sec(1, "replay_end");
    chk("replay_bytes", 64'(bytes_sent), 64'd12);
    chk("replay_queue_empty", 64'(exp_q.size()), 64'd0);

    // tx_busy stuck high for 1000 cycles.
    do_abort();
    set_cfg(0, 2, 1, 8'h99, 1'b1);
    push_section(0);
    send_byte(8'h99, 1'b0);
    wait_bytes(1, "stall_first_byte");
    hold = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (tx_start) cnt++;
    end
    chk("stall_tx_start_low", 64'(cnt), 64'd0);
    chk("stall_in_wait", 64'({busy, bytes_sent}), 64'({1'b1, 32'd1}));
    hold = 1'b0;
    wait_sec(1, "stall_end");
    chk("stall_bytes", 64'(bytes_sent), 64'd8);
    chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero-length sections, with and without header.
    do_abort();
    set_cfg(0, 5, 0, 8'h99, 1'b1);
    set_cfg(1, 9, 0, 8'hAA, 1'b0);
    m0 = mem_en_cnt;
    push_section(0);
    send_byte(8'h99, 1'b0);
    wait_sec(1, "zero_hdr_end");
    chk("zero_hdr_bytes", 64'(bytes_sent), 64'd4);
    chk("zero_hdr_queue_empty", 64'(exp_q.size()), 64'd0);
    send_byte(8'hAA, 1'b0);
    n = 0;
    while (!done && n < 20) begin tick(1); n++; end
    chk("zero_nohdr_done_latency", 64'(n), 64'd1);
    chk("zero_no_mem_en", 64'(mem_en_cnt - m0), 64'd0);
    chk("zero_final_bytes", 64'(bytes_sent), 64'd4);

    // Randomised configurations, including address wrap near the top.
    for (int it = 0; it < 4; it++) begin
      do_abort();
      for (int s = 0; s < 2; s++)
        set_cfg(s, int'($urandom_range(0, 32767)), int'($urandom_range(0, 4)),
                8'($urandom), 1'($urandom_range(0, 1)));
      cfg_sync[1] = cfg_sync[0] ^ 8'h5C;
      total = section_bytes(0) + section_bytes(1);
      for (int s = 0; s < 2; s++) begin
        send_byte(cfg_sync[s] ^ 8'h01, 1'b0);
        push_section(s);
        send_byte(cfg_sync[s], 1'b0);
        wait_sec(s + 1, "rand_sec_end");
      end
      chk("rand_done", 64'(done), 64'd1);
      chk("rand_bytes", 64'(bytes_sent), 64'(total));
      chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    // Asynchronous reset in mid-stream.
    do_abort();
    set_cfg(0, 0, 2, 8'h99, 1'b1);
    set_cfg(1, 2, 1, 8'hAA, 1'b0);
    push_section(0);
    send_byte(8'h99, 1'b0);
    wait_bytes(2, "async_reach_byte2");
    #2 resetn = 1'b0;
    #1;
    chk_outputs_zero("async_reset_outputs");
    exp_q.delete();
    tick(2);
    resetn = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_boot_streamer.md
# uart_boot_streamer

Host-side boot-stream engine for the UART loader path. It waits for a per-section sync byte from the core's UART TX, then streams that section's words from a word memory to the core's UART RX as bytes. Each section may be preceded by a 32-bit byte-count header. It generalises the program-then-data download to `NSEC` sections with configurable word width and byte order, plus abort/restart. It sits between a `uart_rx`/`uart_tx` pair and a synchronous read port of a program/input image RAM, and is synthesizable so it can also run on the host-side FPGA.

## Interface
Parameters:
- `NSEC`, default 2: number of sections; must be ≥1.
- `WORD_W`, default 32: memory word width; must be a multiple of 8, at most 64.
- `ADDR_W`, default 15: memory word-address width.
- `BIG_ENDIAN`, default 0: 0 sends payload bytes LSB first; 1 sends them MSB first. Headers are always sent LSB first.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_ready` in 1: 1-cycle strobe; `rx_data` is valid while it is high.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_start` out 1: send request to `uart_tx`.
- `tx_busy` in 1: `uart_tx` busy flag.
- `mem_addr` out ADDR_W: registered word address.
- `mem_en` out 1: read enable. Data returns on `mem_rdata` exactly 1 cycle after a cycle with `mem_en`=1.
- `mem_rdata` in WORD_W: memory read data.
- `sec_base` in NSEC*ADDR_W: section i first word address, in bits [i*ADDR_W +: ADDR_W].
- `sec_len` in NSEC*ADDR_W: section i word count; 0 is legal.
- `sec_sync` in NSEC*8: sync byte for section i (for example 0x99, 0xAA).
- `sec_hdr` in NSEC: 1 means send a length header before section i.
- `abort` in 1: synchronous restart to section 0.
- `sec_idx` out $clog2(NSEC)+1: current section.
- `busy` out 1: high while a section is being transmitted.
- `done` out 1: high after the last section, sticky until abort or reset.
- `bytes_sent` out 32: total bytes handed to `uart_tx` since reset or abort; wraps modulo 2^32.

## Operation
- Config inputs (`sec_base`, `sec_len`, `sec_sync`, `sec_hdr`) are sampled when section i leaves `SYNC`; they must be held stable from then until the section ends.
- States: `SYNC`, `HDR_SEND`, `HDR_WAIT`, `FETCH`, `LOAD`, `BYTE_SEND`, `BYTE_WAIT`, `DONE`.
- `SYNC`: a cycle with `rx_ready`=1 and `rx_data`==`sec_sync[sec_idx]` moves to `HDR_SEND` if `sec_hdr` is set, otherwise to `FETCH`. Any other byte is ignored.
- Header value = `sec_len*(WORD_W/8)`, computed in 32 bits (truncated). Its 4 bytes go out LSB first through `HDR_SEND`/`HDR_WAIT`, then the FSM enters `FETCH`.
- Zero-length section: from `FETCH`, go directly to the next section. The header, if enabled, is still sent with value 0.
- `FETCH`: drive `mem_addr`=base+word index (modulo 2^ADDR_W) with `mem_en`=1.
- `LOAD`: capture `mem_rdata` into the shift register.
- Bytes go out through `BYTE_SEND`/`BYTE_WAIT` in the `BIG_ENDIAN` order. After WORD_W/8 bytes: if word index+1 < len, go to `FETCH`; otherwise the section ends.
- Section end: `sec_idx`+1. If it now equals `NSEC`, enter `DONE`; otherwise return to `SYNC`.
- TX handshake, identical for header and payload bytes:
  - `*_SEND` sets `tx_data` and holds `tx_start`=1 with `tx_data` stable until `tx_busy`=1 is sampled.
  - In that cycle `tx_start` is cleared and the FSM moves to `*_WAIT`; `bytes_sent` increments there.
  - `*_WAIT` advances when `tx_busy`=0 is sampled.
- RX bytes arriving outside `SYNC` are ignored, including sync bytes received during transmission.
- `abort`=1: next state is `SYNC` with `sec_idx`=0 and `tx_start`=0; `done`, `busy`, `bytes_sent` and the word/byte counters are cleared. `abort` wins over every other event in the same cycle. A byte already in `uart_tx` completes on the line; the FSM does not wait for it.
- `busy`=1 in every state except `SYNC` and `DONE`.

## Timing
- Reset values: all outputs 0, state `SYNC`, all counters 0.
- Sync byte to first `tx_start`=1:
  - 1 cycle with header.
  - 3 cycles without header: `FETCH`, then `LOAD`, then `BYTE_SEND`.
- Between words: 2 extra cycles (`FETCH`, `LOAD`) after the last `BYTE_WAIT` exit.
- `tx_start` is deasserted no later than 1 cycle after the cycle in which `tx_busy`=1 is first sampled.
- A `tx_busy` that never rises is a legal stall; there is no timeout.
- `done` rises 1 cycle after the last `BYTE_WAIT` exit. For a zero-length last section without header, it rises 1 cycle after `FETCH`.

## Test plan
- NSEC=2, WORD_W=32, little-endian, sec0 = base 0, len 2, sync 0x99, header on; RAM = 0x11223344, 0x55667788.
  - Send 0x99 → TX sequence 08 00 00 00 44 33 22 11 88 77 66 55.
  - `bytes_sent`=12, then `SYNC` with `sec_idx`=1.
- Continue with sec1 = base 2, len 1, sync 0xAA, no header, RAM[2]=0xDEADBEEF.
  - Send 0x55 → nothing is sent.
  - Send 0xAA → EF BE AD DE; `done`=1, `bytes_sent`=16.
- BIG_ENDIAN=1, single section, len 1, RAM=0x11223344 → 11 22 33 44. The header, if enabled, stays 04 00 00 00.
- sec_len=0 with header → 00 00 00 00 and no `mem_en` pulse. sec_len=0 without header → no TX, immediate advance to the next section.
- `abort` during the 3rd payload byte while `tx_busy`=1 → next cycle: `SYNC`, `sec_idx`=0, `bytes_sent`=0, `tx_start`=0. Re-sending the sync byte replays the section from its header.
- Assert `resetn`=0 asynchronously in mid-stream → all outputs 0 immediately, with no clock edge required. `tx_busy` held high for 1000 cycles → `tx_start` stays low and the FSM stays in `*_WAIT`.
